// File: rtl/bcd_display_ctrl.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3, one bit per clock)
// driving a multiplexed common-anode 7-segment display. Optional: BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_ctrl #(
  parameter int N           = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] value,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [3:0]   an,
  output logic [6:0]   seg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [N-1:0] MAXV = N'(9999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [N-1:0]  bin, bin_sh;
  logic [15:0]   bcd, bcd_adj, bcd_sh;
  logic [3:0]    cnt;
  logic          ovf_pend;
  logic [15:0]   disp;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic          blank;
  logic          last;

  assign last = (cnt == 4'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Add-3 correction per nibble, then one left shift of {bcd, bin}.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign bcd_sh = {bcd_adj[14:0], bin[N-1]};
  assign bin_sh = {bin[N-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin      <= (value > MAXV) ? MAXV : value;
          ovf_pend <= (value > MAXV);
          bcd      <= '0;
          cnt      <= '0;
        end
        SHIFT: begin
          bcd <= bcd_sh;
          bin <= bin_sh;
          cnt <= cnt + 4'd1;
          // Commit uses this edge's shifted value so done and display update together.
          if (last) begin
            disp <= bcd_sh;
            ovf  <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign digit = disp[{idx, 2'b00} +: 4];

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank = (idx != 2'd0) && ((disp >> {idx, 2'b00}) == 16'd0);
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    an  = 4'b1111;
    seg = 7'b1111111;
    if (!blank) begin
      an  = ~(4'b0001 << idx);
      seg = seg_dec(digit);
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Randomized self-checking bench for bcd_display_ctrl against an arithmetic reference model.
module tb_bcd_display_ctrl;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] value = '0;
  logic        busy, done, ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  int   vectors = 0;
  int   miscompares = 0;
  int   edges;
  int   cur_v = 0;
  logic cur_ovf = 1'b0;

  bcd_display_ctrl #(.N(14), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .ovf(ovf), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; scan slot = (edges / RD) mod 4.
  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [10:0] model_slot(input int v, input int slot);
    int   p = (slot == 0) ? 1 : (slot == 1) ? 10 : (slot == 2) ? 100 : 1000;
    logic blank = 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank = (slot != 0) && (v / p == 0);
`endif
    if (blank) return {4'b1111, 7'b1111111};
    return {~(4'b0001 << slot), seg_code((v / p) % 10)};
  endfunction

  task automatic test_reset();
    logic [10:0] exp;
    rst = 1'b1;
    #2;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset ovf: got %b want 0", ovf); end
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL reset an: got %b want 1110", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("FAIL reset seg: got %b want 1000000", seg); end
    @(negedge clk); rst = 1'b0;
    cur_v = 0; cur_ovf = 1'b0;
    repeat (16) begin
      @(negedge clk);
      exp = model_slot(0, (edges / RD) % 4);
      vectors++;
      if ({an, seg} !== exp) begin
        miscompares++; $display("FAIL reset scan: got an=%b seg=%b want an=%b seg=%b", an, seg, exp[10:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_convert(input int v, input string name);
    int          nv = (v > 9999) ? 9999 : v;
    logic        novf = (v > 9999);
    logic [10:0] exp;
    @(posedge clk); #1 start = 1'b1; value = 14'(v);
    @(posedge clk); #1 start = 1'b0; value = 14'($urandom_range(0, 16383));
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        vectors++;
        if (busy !== (c <= 15)) begin miscompares++; $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, c <= 15); end
        vectors++;
        if (done !== (c == 15)) begin miscompares++; $display("FAIL %s done c%0d: got %b want %b", name, c, done, c == 15); end
      end
      if (c == 15) begin cur_v = nv; cur_ovf = novf; end
      vectors++;
      if (ovf !== cur_ovf) begin miscompares++; $display("FAIL %s ovf c%0d: got %b want %b", name, c, ovf, cur_ovf); end
      exp = model_slot(cur_v, (edges / RD) % 4);
      vectors++;
      if ({an, seg} !== exp) begin
        miscompares++; $display("FAIL %s disp c%0d: got an=%b seg=%b want an=%b seg=%b", name, c, an, seg, exp[10:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_ignore();
    int          dn = 0;
    int          v2 = $urandom_range(0, 16383);
    int          n2 = (v2 > 9999) ? 9999 : v2;
    bit          seen = 0;
    logic [10:0] exp;
    @(posedge clk); #1 start = 1'b1; value = 14'd1234;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      vectors++;
      if (busy !== (c <= 15)) begin miscompares++; $display("FAIL ignore busy c%0d: got %b want %b", c, busy, c <= 15); end
      start = (c + 1 >= 3 && c + 1 <= 10);
      value = 14'd5678;
    end
    vectors++;
    if (dn != 1) begin miscompares++; $display("FAIL ignore done count: got %0d want 1", dn); end
    cur_v = 1234; cur_ovf = 1'b0;
    exp = model_slot(cur_v, (edges / RD) % 4);
    vectors++;
    if ({an, seg} !== exp) begin miscompares++; $display("FAIL ignore disp: got an=%b seg=%b want an=%b seg=%b", an, seg, exp[10:7], exp[6:0]); end
    start = 1'b1; value = 14'(v2);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL ignore restart busy: got %b want 1", busy); end
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL ignore restart done: got timeout want pulse"); end
    cur_v = n2; cur_ovf = (v2 > 9999);
    exp = model_slot(cur_v, (edges / RD) % 4);
    vectors++;
    if ({an, seg, ovf} !== {exp, cur_ovf}) begin
      miscompares++; $display("FAIL ignore restart result: got an=%b seg=%b ovf=%b want an=%b seg=%b ovf=%b", an, seg, ovf, exp[10:7], exp[6:0], cur_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 start = 1'b1; value = 14'd4321;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL midrst pre c%0d: got busy,done=%b want 10", c, {busy, done}); end
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    cur_v = 0; cur_ovf = 1'b0;
    vectors++;
    if ({busy, done, ovf, an, seg} !== {3'b000, 4'b1110, 7'b1000000}) begin
      miscompares++; $display("FAIL midrst clear: got b/d/o=%b an=%b seg=%b want 000 1110 1000000", {busy, done, ovf}, an, seg);
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL midrst idle: got busy,done=%b want 00", {busy, done}); end
    end
    test_convert(7, "after_rst");
  endtask

  initial begin
    test_reset();
    test_convert(1234, "v1234");
    test_convert(12000, "v12000");
    test_convert(9999, "v9999");
    test_convert(16383, "v16383");
    test_ignore();
    test_reset_mid();
    test_convert(42, "v42");
    test_convert(0, "v0");
    repeat (8) test_convert($urandom_range(0, 16383), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
